// File: rtl/pipelined_control_unit_pkg.sv
// Shared control types for the pipelined control unit: opcodes, ALUOp codes,
// the per-stage control bundle and the flush FSM state encoding.
package ctrl_pkg;

  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;

  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] SUB    = 2'b01;
  localparam logic [1:0] R_TYPE = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

  typedef enum logic {
    RUN,
    FLUSH
  } ctrl_state_e;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ID-stage inputs and per-stage control outputs of the control unit.
// Perf counter signals exist only when CTRL_PERF_COUNTERS_EN is defined.
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  reg_equal;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  redirect;
  logic [1:0]            ex_alu_op;
  logic                  ex_alu_src;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  wb_mem_2_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_opcode, id_rs1, id_rs2, id_rd, reg_equal,
    input  pc_write, if_id_write, redirect,
    input  ex_alu_op, ex_alu_src, ex_mem_read, ex_rd,
    input  mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
    input  wb_mem_2_reg, wb_reg_write, wb_rd,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, id_rd, reg_equal,
    output pc_write, if_id_write, redirect,
    output ex_alu_op, ex_alu_src, ex_mem_read, ex_rd,
    output mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
    output wb_mem_2_reg, wb_reg_write, wb_rd,
    output stall_cnt, flush_cnt
  );
`else
  modport master (
    output id_opcode, id_rs1, id_rs2, id_rd, reg_equal,
    input  pc_write, if_id_write, redirect,
    input  ex_alu_op, ex_alu_src, ex_mem_read, ex_rd,
    input  mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
    input  wb_mem_2_reg, wb_reg_write, wb_rd
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, id_rd, reg_equal,
    output pc_write, if_id_write, redirect,
    output ex_alu_op, ex_alu_src, ex_mem_read, ex_rd,
    output mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
    output wb_mem_2_reg, wb_reg_write, wb_rd
  );
`endif

endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational opcode decoder for the ID stage; unknown opcodes decode to BUBBLE.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output ctrl_bundle_t ctrl_o
);

  always_comb begin
    ctrl_o = BUBBLE;
    case (opcode_i)
      ALU_R: begin
        ctrl_o.alu_op    = R_TYPE;
        ctrl_o.reg_write = 1'b1;
      end
      ALU_I: begin
        ctrl_o.alu_op    = ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      LOAD: begin
        ctrl_o.alu_op    = ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.mem_2_reg = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      STORE: begin
        ctrl_o.alu_op    = ADD;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      BRANCH_EQ: begin
        ctrl_o.alu_op = SUB;
        ctrl_o.branch = 1'b1;
      end
      JUMP: begin
        ctrl_o.alu_op = ADD;
        ctrl_o.jump   = 1'b1;
      end
      default: ctrl_o = BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and branch/jump flush window. Optional CTRL_PERF_COUNTERS_EN.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_control_unit_if.slave bus
);

  typedef struct packed {
    ctrl_bundle_t          ctrl;
    logic [REG_ADDR_W-1:0] rd;
  } stage_t;

  ctrl_bundle_t id_ctrl;
  stage_t       id_ex_d, id_ex_q, ex_mem_q, mem_wb_q;
  ctrl_state_e  state_q;
  logic [2:0]   slot_cnt_q;
  logic         in_run;
  logic         hazard;
  logic         take;

  ctrl_decoder u_decoder (
    .opcode_i (bus.id_opcode),
    .ctrl_o   (id_ctrl)
  );

  assign in_run = (state_q == RUN);

  // A load in EX whose rd feeds either ID source must wait one cycle.
  assign hazard = !rst && in_run && id_ex_q.ctrl.mem_read && (id_ex_q.rd != '0) &&
                  ((id_ex_q.rd == bus.id_rs1) || (id_ex_q.rd == bus.id_rs2));

  assign take = !rst && in_run && !hazard &&
                ((id_ctrl.branch && bus.reg_equal) || id_ctrl.jump);

  always_comb begin
    id_ex_d.ctrl = id_ctrl;
    id_ex_d.rd   = (id_ctrl == BUBBLE) ? '0 : bus.id_rd;
    if (!in_run || hazard) begin
      id_ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      state_q    <= RUN;
      slot_cnt_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= id_ex_q;
      mem_wb_q <= ex_mem_q;
      case (state_q)
        RUN: begin
          if (take) begin
            state_q    <= FLUSH;
            slot_cnt_q <= 3'(FLUSH_SLOTS);
          end
        end
        FLUSH: begin
          if (slot_cnt_q <= 3'd1) begin
            state_q    <= RUN;
            slot_cnt_q <= '0;
          end else begin
            slot_cnt_q <= slot_cnt_q - 3'd1;
          end
        end
        default: begin
          state_q    <= RUN;
          slot_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.pc_write      = !hazard;
  assign bus.if_id_write   = !hazard;
  assign bus.redirect      = take;

  assign bus.ex_alu_op     = id_ex_q.ctrl.alu_op;
  assign bus.ex_alu_src    = id_ex_q.ctrl.alu_src;
  assign bus.ex_mem_read   = id_ex_q.ctrl.mem_read;
  assign bus.ex_rd         = id_ex_q.rd;

  assign bus.mem_mem_read  = ex_mem_q.ctrl.mem_read;
  assign bus.mem_mem_write = ex_mem_q.ctrl.mem_write;
  assign bus.mem_rd        = ex_mem_q.rd;
  assign bus.mem_reg_write = ex_mem_q.ctrl.reg_write;

  assign bus.wb_mem_2_reg  = mem_wb_q.ctrl.mem_2_reg;
  assign bus.wb_reg_write  = mem_wb_q.ctrl.reg_write;
  assign bus.wb_rd         = mem_wb_q.rd;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (!in_run && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit with a three-deep expected-bundle scoreboard.
module tb_pipelined_control_unit;

  localparam int FS = 3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
    logic [4:0] rd;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_stalls = 0;
  int   exp_flushes = 0;
  exp_t q[$];

  pipelined_control_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

  pipelined_control_unit #(
    .REG_ADDR_W  (5),
    .FLUSH_SLOTS (FS),
    .CNT_W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic exp_t exp_of(input logic [6:0] op, input logic [4:0] rd);
    exp_t e;
    e = '0;
    case (op)
      OP_R:   begin e.alu_op = 2'b10; e.reg_write = 1'b1; e.rd = rd; end
      OP_I:   begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.rd = rd; end
      OP_LD:  begin e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_2_reg = 1'b1;
                    e.reg_write = 1'b1; e.rd = rd; end
      OP_ST:  begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.rd = rd; end
      OP_BEQ: begin e.alu_op = 2'b01; e.rd = rd; end
      OP_JAL: begin e.rd = rd; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // One ID cycle: drive, check same-cycle controls, push expectation, clock, check stages.
  task automatic cyc(input logic r, input logic [6:0] op, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [4:0] rd, input logic req,
                     input logic hold, input logic bub, input logic redir, input string name);
    exp_t e;
    exp_t e_ex, e_mem, e_wb;
    rst           = r;
    bus.id_opcode = op;
    bus.id_rs1    = rs1;
    bus.id_rs2    = rs2;
    bus.id_rd     = rd;
    bus.reg_equal = req;
    #2;
    checks++;
    if ({bus.pc_write, bus.if_id_write, bus.redirect} !== {~hold, ~hold, redir}) begin
      errors++;
      $display("FAIL %s ctl: got pc_write=%b if_id_write=%b redirect=%b, want %b %b %b",
               name, bus.pc_write, bus.if_id_write, bus.redirect, ~hold, ~hold, redir);
    end
    if (r) begin
      q.delete();
      repeat (3) q.push_back('0);
      exp_stalls = 0;
      exp_flushes = 0;
    end else begin
      e = (hold || bub) ? '0 : exp_of(op, rd);
      q.push_back(e);
      if (hold) exp_stalls++;
      if (bub) exp_flushes++;
    end
    @(posedge clk);
    #1;
    e_ex  = q[2];
    e_mem = q[1];
    e_wb  = q.pop_front();
    checks++;
    if ({bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_read, bus.ex_rd} !==
        {e_ex.alu_op, e_ex.alu_src, e_ex.mem_read, e_ex.rd}) begin
      errors++;
      $display("FAIL %s ex: got op=%b src=%b mrd=%b rd=%0d, want op=%b src=%b mrd=%b rd=%0d",
               name, bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_read, bus.ex_rd,
               e_ex.alu_op, e_ex.alu_src, e_ex.mem_read, e_ex.rd);
    end
    checks++;
    if ({bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_rd} !==
        {e_mem.mem_read, e_mem.mem_write, e_mem.reg_write, e_mem.rd}) begin
      errors++;
      $display("FAIL %s mem: got rd_en=%b wr_en=%b regw=%b rd=%0d, want %b %b %b rd=%0d",
               name, bus.mem_mem_read, bus.mem_mem_write, bus.mem_reg_write, bus.mem_rd,
               e_mem.mem_read, e_mem.mem_write, e_mem.reg_write, e_mem.rd);
    end
    checks++;
    if ({bus.wb_mem_2_reg, bus.wb_reg_write, bus.wb_rd} !==
        {e_wb.mem_2_reg, e_wb.reg_write, e_wb.rd}) begin
      errors++;
      $display("FAIL %s wb: got m2r=%b regw=%b rd=%0d, want m2r=%b regw=%b rd=%0d",
               name, bus.wb_mem_2_reg, bus.wb_reg_write, bus.wb_rd,
               e_wb.mem_2_reg, e_wb.reg_write, e_wb.rd);
    end
`ifdef CTRL_PERF_COUNTERS_EN
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt} !== {16'(exp_stalls), 16'(exp_flushes)}) begin
      errors++;
      $display("FAIL %s perf: got stall_cnt=%0d flush_cnt=%0d, want %0d %0d",
               name, bus.stall_cnt, bus.flush_cnt, exp_stalls, exp_flushes);
    end
`endif
  endtask

  task automatic run(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic req, input logic hold,
                     input logic bub, input logic redir, input string name);
    cyc(1'b0, op, rs1, rs2, rd, req, hold, bub, redir, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic test_reset();
    cyc(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_jal");
    cyc(1'b1, OP_LD,  5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_load");
  endtask

  task automatic test_alu();
    run(OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, "r_type");
    run(OP_I, 5'd4, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, "i_type");
    run(7'b1111111, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, "unknown");
    idle(3);
  endtask

  task automatic test_load_use();
    run(OP_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, "ld_rd5");
    run(OP_R,  5'd5, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, "use_rs1_stall");
    run(OP_R,  5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, "use_rs1_go");
    run(OP_LD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, "ld_rd4");
    run(OP_ST, 5'd8, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "use_rs2_stall");
    run(OP_ST, 5'd8, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "use_rs2_go");
    run(OP_LD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "ld_rd0");
    run(OP_R,  5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, "rd0_no_stall");
    idle(3);
  endtask

  task automatic test_branch();
    run(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
    run(OP_JAL, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "flush_ignores_jal");
    for (int i = 1; i < FS; i++) run(OP_R, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, "beq_flush");
    run(OP_R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, "after_flush");
    run(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "beq_not_taken");
    run(OP_R,   5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, "no_bubble");
    idle(3);
  endtask

  task automatic test_jal();
    run(OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "jal");
    for (int i = 0; i < FS; i++) run(OP_ST, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "jal_flush_store");
    run(OP_ST, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "store_after_flush");
    run(OP_I,  5'd1, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, "i_after_flush");
    idle(3);
  endtask

  task automatic test_hazard_branch();
    run(OP_LD,  5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, "ld_rd2");
    run(OP_BEQ, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, "beq_stall_wins");
    run(OP_BEQ, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "beq_reeval");
    for (int i = 0; i < FS; i++) run(OP_R, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, "hb_flush");
    idle(3);
  endtask

  task automatic test_reset_abort();
    run(OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "jal_then_rst");
    run(OP_R,   5'd1, 5'd2, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0, "flush_slot1");
    cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0, "rst_in_flush");
    run(OP_R,   5'd1, 5'd2, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, "run_after_rst");
    run(OP_LD,  5'd1, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, "ld_rd6");
    cyc(1'b1, OP_R, 5'd6, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, "rst_in_stall");
    run(OP_R,   5'd6, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, "go_after_rst");
    idle(3);
  endtask

  initial begin
    rst           = 1'b1;
    bus.id_opcode = OP_NOP;
    bus.id_rs1    = '0;
    bus.id_rs2    = '0;
    bus.id_rd     = '0;
    bus.reg_equal = 1'b0;
    test_reset();
    test_alu();
    test_load_use();
    test_branch();
    test_jal();
    test_hazard_branch();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Successor to the single-cycle control decoder. Decodes the RISC-V opcode in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use hazard detection (stall) and a parametrised branch/jump flush window.
- Sits between the IF/ID register and the datapath stage registers. Drives PC/IF-ID write enables and per-stage control.

Parameters:
- REG_ADDR_W, 5, register-index width for rs1/rs2/rd.
- FLUSH_SLOTS, 1, bubbles inserted after a taken branch/jump (1..7).
- CNT_W, 16, perf counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction
- id_rd  in  REG_ADDR_W  destination register of the ID instruction
- reg_equal  in  1  forwarded rs1==rs2 comparison in ID
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- redirect  out  1  take branch/jump target this cycle
- ex_alu_op  out  2  ALUOp in EX
- ex_alu_src  out  1  ALU operand select in EX
- ex_mem_read  out  1  load in EX (for hazard/forwarding)
- ex_rd  out  REG_ADDR_W  rd in EX
- mem_mem_read  out  1  memory read enable
- mem_mem_write  out  1  memory write enable
- mem_rd  out  REG_ADDR_W  rd in MEM
- mem_reg_write  out  1  reg_write in MEM (forwarding)
- wb_mem_2_reg  out  1  writeback select
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  REG_ADDR_W  rd in WB

Behaviour:
- Decode (combinational, ID):
  - R: alu_src 0, alu_op 10, reg_write 1.
  - I-ALU: alu_src 1, alu_op 00, reg_write 1.
  - LOAD: alu_src 1, mem_read 1, mem_2_reg 1, reg_write 1, alu_op 00.
  - STORE: alu_src 1, mem_write 1, alu_op 00.
  - BEQ: alu_op 01.
  - JAL: alu_op 00.
  - Unknown opcode: all-zero bundle (bubble). Bubble has alu_op 00 and rd 0.
- Stage registers update every cycle; no stage ever holds. Bundle reaches the ex_* outputs 1 cycle after ID, mem_* after 2, wb_* after 3.
- Load-use hazard:
  - Condition: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2.
  - Response: pc_write=0, if_id_write=0, bubble into ID/EX, redirect=0 that cycle.
  - rs2 is compared for all opcodes.
  - Exactly one stall cycle per load-use hazard.
- Redirect:
  - Asserted when not stalled, state RUN, and either (BEQ and reg_equal=1) or JAL.
  - The branch/jump itself enters ID/EX as its decoded bundle: no reg_write, no memory access.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on redirect. Flush counter loads FLUSH_SLOTS.
  - In FLUSH: ID bundle is replaced by a bubble; pc_write=1, if_id_write=1; counter decrements.
  - FLUSH -> RUN when the counter reaches 1.
  - In FLUSH, hazard detection and redirect are ignored.
- Priority: rst > stall > redirect.
- Reset:
  - All stage registers cleared (bubble, rd 0); state RUN; counter 0.
  - During rst: pc_write=1, if_id_write=1, redirect=0.
  - Reset mid-flush or mid-stall aborts the operation immediately.
- Simultaneous hazard and taken branch: stall wins; the branch is re-evaluated the next cycle with the forwarded reg_equal.

Optional Feature:
- Macro: CTRL_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt, each CNT_W wide, registered.
  - stall_cnt increments on each stall cycle; flush_cnt increments on each FLUSH-state cycle.
  - Both saturate at all-ones and clear on rst.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode constants: ALU_R, ALU_I, BRANCH_EQ, JUMP, LOAD, STORE.
  - ALUOp constants: ADD 00, SUB 01, R_TYPE 10.
  - Packed ctrl_bundle_t: alu_op, alu_src, mem_read, mem_write, mem_2_reg, reg_write, branch, jump.
  - BUBBLE constant.
  - FSM state enum.
- Sub-module ctrl_decoder: purely combinational, opcode -> ctrl_bundle_t. Instantiated once in ID.

Test Plan:
- R-type add, rd=3, after rst: ex_alu_op=10 at cycle+1, wb_reg_write=1 and wb_rd=3 at cycle+3, no stall.
- LOAD rd=5, then R-type rs1=5: one cycle with pc_write=0, if_id_write=0 and ex bundle all-zero; R-type reaches EX the following cycle.
- BEQ with reg_equal=1, FLUSH_SLOTS=1: redirect=1 for 1 cycle; next ID instruction appears as a bubble in EX. With reg_equal=0: no redirect, no bubble.
- JAL with FLUSH_SLOTS=3: exactly 3 consecutive bubbles, then RUN; a STORE in the flush window never drives mem_mem_write.
- LOAD rd=2, then BEQ rs1=2 with reg_equal=1: stall first, redirect on the following cycle.
- rst asserted in the 2nd flush cycle: all outputs cleared next edge, state RUN; with CTRL_PERF_COUNTERS_EN, flush_cnt=0.
